// File: rtl/crossbar_mvm_engine_pkg.sv
// Shared definitions for the crossbar matrix-vector engine: FSM state
// encoding, default operand widths and index/accumulator width helpers.
package crossbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int DEF_DW = 8;
  localparam int DEF_OW = 8;

  // Width of an index able to address n entries (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: a full product plus headroom for summing cols terms.
  function automatic int acc_width(input int dw, input int cols);
    return 2 * dw + $clog2(cols);
  endfunction

endpackage

// File: rtl/crossbar_mvm_engine_if.sv
// Bundle of the weight-write, vector-input and result handshakes of the
// crossbar engine. slave = engine side, master = host side.
interface crossbar_mvm_engine_if
  import crossbar_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = DEF_DW,
  parameter int OW   = DEF_OW
);
  localparam int RW = idx_width(ROWS);
  localparam int CW = idx_width(COLS);

  logic                 w_valid;
  logic                 w_ready;
  logic [RW-1:0]        w_row;
  logic [CW-1:0]        w_col;
  logic [DW-1:0]        w_data;
  logic                 w_err;
  logic                 x_valid;
  logic                 x_ready;
  logic [COLS*DW-1:0]   x;
  logic                 b_valid;
  logic                 b_ready;
  logic [ROWS*OW-1:0]   b;
  logic                 busy;

  modport slave (
    input  w_valid, w_row, w_col, w_data, x_valid, x, b_ready,
    output w_ready, w_err, x_ready, b_valid, b, busy
  );

  modport master (
    output w_valid, w_row, w_col, w_data, x_valid, x, b_ready,
    input  w_ready, w_err, x_ready, b_valid, b, busy
  );

endinterface

// File: rtl/crossbar_mvm_engine_mac_lane.sv
// One row of the crossbar: accumulates weight*x one column per cycle and
// converts the final sum to the output width (truncate or saturate).
module crossbar_mac_lane #(
  parameter int DW  = 8,
  parameter int OW  = 8,
  parameter int AW  = 19,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          acc_en,
  input  logic          load_out,
  input  logic [DW-1:0] w_val,
  input  logic [DW-1:0] x_val,
  output logic [OW-1:0] b_out
);
  logic [AW-1:0]   acc_reg;
  logic [AW-1:0]   acc_next;
  logic [2*DW-1:0] prod;
  logic [OW-1:0]   conv;
  logic [OW-1:0]   b_reg;

  assign prod     = w_val * x_val;
  assign acc_next = acc_reg + AW'(prod);

  // Conversion sees acc_next so the last column is included on the OUT entry edge.
  generate
    if (OW >= AW) begin : g_wide
      assign conv = OW'(acc_next);
    end else if (SAT != 0) begin : g_sat
      assign conv = (acc_next > AW'({OW{1'b1}})) ? {OW{1'b1}} : acc_next[OW-1:0];
    end else begin : g_trunc
      assign conv = acc_next[OW-1:0];
    end
  endgenerate

  // Accumulator: cleared on vector accept, summed during ACC.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_reg <= '0;
    end else if (acc_en) begin
      acc_reg <= acc_next;
    end
  end

  // Output register: captured once when the last column is summed, then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_reg <= '0;
    end else if (load_out) begin
      b_reg <= conv;
    end
  end

  assign b_out = b_reg;

endmodule

// File: rtl/crossbar_mvm_engine.sv
// Crossbar matrix-vector engine: weight store, vector latch, column counter
// and handshake FSM around ROWS parallel MAC lanes.
module crossbar_mvm_engine
  import crossbar_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = DEF_DW,
  parameter int OW   = DEF_OW,
  parameter int AW   = acc_width(DW, COLS),
  parameter int SAT  = 0
) (
  input logic clk,
  input logic rst,
  crossbar_mvm_engine_if.slave bus
);
  localparam int CW = idx_width(COLS);

  state_t             state_reg, state_next;
  logic [CW-1:0]      idx_reg;
  logic [COLS*DW-1:0] x_lat_reg;
  logic [DW-1:0]      w_mem [ROWS][COLS];
  logic               w_err_reg;
  logic               w_fire, x_fire, w_in_range, last_col;
  logic               lane_en, lane_load;
  logic [OW-1:0]      b_lane [ROWS];
  logic [ROWS*OW-1:0] b_pack;

  assign w_fire     = bus.w_valid && bus.w_ready;
  assign x_fire     = bus.x_valid && bus.x_ready;
  assign w_in_range = (int'(bus.w_row) < ROWS) && (int'(bus.w_col) < COLS);
  assign last_col   = (idx_reg == CW'(COLS - 1));
  assign lane_en    = (state_reg == ST_ACC);
  assign lane_load  = (state_reg == ST_ACC) && last_col;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next  = state_reg;
    bus.w_ready = 1'b0;
    bus.x_ready = 1'b0;
    bus.b_valid = 1'b0;
    bus.busy    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.w_ready = 1'b1;
        bus.x_ready = 1'b1;
        if (bus.x_valid) state_next = ST_ACC;
      end
      ST_ACC: begin
        bus.busy = 1'b1;
        if (last_col) state_next = ST_OUT;
      end
      ST_OUT: begin
        bus.busy    = 1'b1;
        bus.b_valid = 1'b1;
        if (bus.b_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Column counter and vector latch; x is only sampled at the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg   <= '0;
      x_lat_reg <= '0;
    end else if (x_fire) begin
      idx_reg   <= '0;
      x_lat_reg <= bus.x;
    end else if (state_reg == ST_ACC) begin
      idx_reg <= last_col ? '0 : idx_reg + CW'(1);
    end
  end

  // Weight store: reset-cleared, written only in IDLE, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          w_mem[r][c] <= '0;
    end else if (w_fire && w_in_range) begin
      w_mem[bus.w_row][bus.w_col] <= bus.w_data;
    end
  end

  // One-cycle error pulse for a consumed write with a bad index.
  always_ff @(posedge clk) begin
    if (rst) w_err_reg <= 1'b0;
    else     w_err_reg <= w_fire && !w_in_range;
  end

  assign bus.w_err = w_err_reg;

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
      crossbar_mac_lane #(
        .DW (DW),
        .OW (OW),
        .AW (AW),
        .SAT(SAT)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .clr     (x_fire),
        .acc_en  (lane_en),
        .load_out(lane_load),
        .w_val   (w_mem[gi][idx_reg]),
        .x_val   (x_lat_reg[idx_reg*DW +: DW]),
        .b_out   (b_lane[gi])
      );
    end
  endgenerate

  // Pack lane results into the flat result bus.
  always_comb begin
    b_pack = '0;
    for (int r = 0; r < ROWS; r++) b_pack[r*OW +: OW] = b_lane[r];
  end

  assign bus.b = b_pack;

endmodule

// File: tb/tb_crossbar_mvm_engine.sv
// Scoreboard bench: 8x8 truncating and saturating engines share stimulus,
// a 6x5 engine covers non-power-of-two index checking.
module tb_crossbar_mvm_engine;

  logic clk = 1'b0;
  logic rst, rst2;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [63:0] qa[$];
  logic [63:0] qs[$];
  logic [63:0] qn[$];

  always #5 clk = ~clk;

  crossbar_mvm_engine_if #(.ROWS(8), .COLS(8), .DW(8), .OW(8)) ifa ();
  crossbar_mvm_engine_if #(.ROWS(8), .COLS(8), .DW(8), .OW(8)) ifs ();
  crossbar_mvm_engine_if #(.ROWS(6), .COLS(5), .DW(8), .OW(8)) ifn ();

  crossbar_mvm_engine #(.ROWS(8), .COLS(8), .DW(8), .OW(8), .SAT(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  crossbar_mvm_engine #(.ROWS(8), .COLS(8), .DW(8), .OW(8), .SAT(1))
    dut_s (.clk(clk), .rst(rst), .bus(ifs));
  crossbar_mvm_engine #(.ROWS(6), .COLS(5), .DW(8), .OW(8), .SAT(0))
    dut_n (.clk(clk), .rst(rst2), .bus(ifn));

  assign ifs.w_valid = ifa.w_valid;
  assign ifs.w_row   = ifa.w_row;
  assign ifs.w_col   = ifa.w_col;
  assign ifs.w_data  = ifa.w_data;
  assign ifs.x_valid = ifa.x_valid;
  assign ifs.x       = ifa.x;
  assign ifs.b_ready = ifa.b_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitors pop the scoreboard on each result handshake.
  always @(negedge clk) begin
    if (!rst && ifa.b_valid && ifa.b_ready) begin
      $display("txn trunc: b=%h", ifa.b);
      if (qa.size() == 0) chk("trunc_unexpected_b_valid", 64'(ifa.b_valid), 64'd0);
      else chk("trunc_b", ifa.b, qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && ifs.b_valid && ifs.b_ready) begin
      $display("txn sat: b=%h", ifs.b);
      if (qs.size() == 0) chk("sat_unexpected_b_valid", 64'(ifs.b_valid), 64'd0);
      else chk("sat_b", ifs.b, qs.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst2 && ifn.b_valid && ifn.b_ready) begin
      $display("txn 6x5: b=%h", ifn.b);
      if (qn.size() == 0) chk("n_unexpected_b_valid", 64'(ifn.b_valid), 64'd0);
      else chk("n_b", 64'(ifn.b), qn.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int row, input int col, input logic [7:0] d);
    int g = 0;
    while (!ifa.w_ready && g < 50) begin tick(); g++; end
    chk("w_ready_wait", 64'(ifa.w_ready), 64'd1);
    ifa.w_valid = 1'b1; ifa.w_row = 3'(row); ifa.w_col = 3'(col); ifa.w_data = d;
    tick();
    ifa.w_valid = 1'b0;
  endtask

  task automatic send_a(input logic [63:0] v);
    int g = 0;
    while (!ifa.x_ready && g < 50) begin tick(); g++; end
    chk("x_ready_wait", 64'(ifa.x_ready), 64'd1);
    ifa.x_valid = 1'b1; ifa.x = v;
    tick();
    ifa.x_valid = 1'b0;
  endtask

  task automatic wr_n(input int row, input int col, input logic [7:0] d);
    ifn.w_valid = 1'b1; ifn.w_row = 3'(row); ifn.w_col = 3'(col); ifn.w_data = d;
    tick();
    ifn.w_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((qa.size() != 0 || qs.size() != 0 || qn.size() != 0) && g < 200) begin tick(); g++; end
    chk("drained", 64'(qa.size() + qs.size() + qn.size()), 64'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; rst2 = 1'b1;
    ifa.w_valid = 1'b0; ifa.w_row = '0; ifa.w_col = '0; ifa.w_data = '0;
    ifa.x_valid = 1'b0; ifa.x = '0; ifa.b_ready = 1'b1;
    ifn.w_valid = 1'b0; ifn.w_row = '0; ifn.w_col = '0; ifn.w_data = '0;
    ifn.x_valid = 1'b0; ifn.x = '0; ifn.b_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_w_ready", 64'(ifa.w_ready), 64'd1);
    chk("rst_x_ready", 64'(ifa.x_ready), 64'd1);
    chk("rst_b_valid", 64'(ifa.b_valid), 64'd0);
    chk("rst_w_err",   64'(ifa.w_err),   64'd0);
    chk("rst_busy",    64'(ifa.busy),    64'd0);
    chk("rst_b",       ifa.b,            64'd0);
    chk("rst_n_ready", 64'(ifn.x_ready), 64'd1);
    rst = 1'b0; rst2 = 1'b0;
    tick();

    // Identity matrix, x element c = c+1
    for (int r = 0; r < 8; r++) wr_a(r, r, 8'd1);
    qa.push_back(64'h0807060504030201);
    qs.push_back(64'h0807060504030201);
    send_a(64'h0807060504030201);
    chk("acc_busy", 64'(ifa.busy), 64'd1);
    cnt = 0;
    while (!ifa.b_valid && cnt < 30) begin tick(); cnt++; end
    chk("latency", 64'(cnt), 64'd8);
    drain();

    // All weights and all x at 255
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) wr_a(r, c, 8'hFF);
    qa.push_back(64'h0808080808080808);
    qs.push_back(64'hFFFFFFFFFFFFFFFF);
    send_a(64'hFFFFFFFFFFFFFFFF);
    drain();

    // Back-pressure in OUT with a pending write and vector
    ifa.b_ready = 1'b0;
    qa.push_back(64'h0808080808080808);
    qs.push_back(64'hFFFFFFFFFFFFFFFF);
    send_a(64'hFFFFFFFFFFFFFFFF);
    cnt = 0;
    while (!ifa.b_valid && cnt < 30) begin tick(); cnt++; end
    ifa.w_valid = 1'b1; ifa.w_row = 3'd0; ifa.w_col = 3'd0; ifa.w_data = 8'd0;
    ifa.x_valid = 1'b1; ifa.x = 64'h0101010101010101;
    for (int k = 0; k < 5; k++) begin
      chk("hold_b",       ifa.b,             64'h0808080808080808);
      chk("hold_b_valid", 64'(ifa.b_valid),  64'd1);
      chk("hold_w_ready", 64'(ifa.w_ready),  64'd0);
      chk("hold_x_ready", 64'(ifa.x_ready),  64'd0);
      tick();
    end
    qa.push_back(64'hF8F8F8F8F8F8F8F9);
    qs.push_back(64'hFFFFFFFFFFFFFFFF);
    ifa.b_ready = 1'b1;
    tick();
    chk("release_w_ready", 64'(ifa.w_ready), 64'd1);
    chk("release_x_ready", 64'(ifa.x_ready), 64'd1);
    tick();
    ifa.w_valid = 1'b0; ifa.x_valid = 1'b0;
    chk("release_busy", 64'(ifa.busy), 64'd1);
    drain();

    // Reset during the 4th ACC cycle aborts the vector
    send_a(64'hFFFFFFFFFFFFFFFF);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("abort_b_valid", 64'(ifa.b_valid), 64'd0);
    chk("abort_busy",    64'(ifa.busy),    64'd0);
    repeat (12) tick();
    qa.push_back(64'd0);
    qs.push_back(64'd0);
    send_a(64'h0101010101010101);
    drain();

    // Same-cycle write A[2][3]=10 and vector with x[3]=4
    ifa.w_valid = 1'b1; ifa.w_row = 3'd2; ifa.w_col = 3'd3; ifa.w_data = 8'd10;
    ifa.x_valid = 1'b1; ifa.x = 64'h0000000004000000;
    qa.push_back(64'h0000000000280000);
    qs.push_back(64'h0000000000280000);
    tick();
    ifa.w_valid = 1'b0; ifa.x_valid = 1'b0;
    drain();

    // 6x5 engine: out-of-range writes, then a known product
    wr_n(7, 0, 8'd99);
    chk("n_err_row_pulse", 64'(ifn.w_err), 64'd1);
    tick();
    chk("n_err_row_clear", 64'(ifn.w_err), 64'd0);
    wr_n(1, 6, 8'd50);
    chk("n_err_col_pulse", 64'(ifn.w_err), 64'd1);
    wr_n(0, 0, 8'd2);
    chk("n_err_ok_write", 64'(ifn.w_err), 64'd0);
    wr_n(3, 2, 8'd5);
    wr_n(5, 4, 8'd3);
    qn.push_back(64'h0000_0F000F000002);
    ifn.x_valid = 1'b1; ifn.x = 40'h0504030201;
    tick();
    ifn.x_valid = 1'b0;
    cnt = 0;
    while (!ifn.b_valid && cnt < 30) begin tick(); cnt++; end
    chk("n_latency", 64'(cnt), 64'd5);
    drain();

    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qs_empty", 64'(qs.size()), 64'd0);
    chk("qn_empty", 64'(qn.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
